// File: rtl/mem_wb_stage_pkg.sv
// Shared pipeline package: load-type encodings used by the ID, MEM and WB stages.
package mem_wb_stage_pkg;

    typedef enum logic [2:0] {
        LT_LW  = 3'd0,
        LT_LB  = 3'd1,
        LT_LBU = 3'd2,
        LT_LH  = 3'd3,
        LT_LHU = 3'd4
    } loadtype_e;

    localparam int unsigned XLEN = 32;
    localparam int unsigned REG_W = 5;

endpackage

// File: rtl/mem_wb_stage_load_align.sv
// Little-endian load extraction: selects the byte/halfword and sign/zero extends.
module load_align
    import mem_wb_stage_pkg::*;
(
    input  logic [2:0]  loadtype,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] memdata,
    output logic [31:0] data
);

    logic [31:0] shifted;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        shifted  = memdata >> {addr_lo, 3'b000};
        byte_sel = shifted[7:0];
        half_sel = addr_lo[1] ? memdata[31:16] : memdata[15:0];
        data     = memdata;
        case (loadtype)
            LT_LB:   data = {{24{byte_sel[7]}}, byte_sel};
            LT_LBU:  data = {24'd0, byte_sel};
            LT_LH:   data = {{16{half_sel[15]}}, half_sel};
            LT_LHU:  data = {16'd0, half_sel};
            default: data = memdata;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with load alignment, $0 write suppression and retire counter.
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic             in_valid,
    input  logic             in_regwrite,
    input  logic             in_memtoreg,
    input  logic [2:0]       in_loadtype,
    input  logic [1:0]       in_addr_lo,
    input  logic [31:0]      in_aluresult,
    input  logic [31:0]      in_memdata,
    input  logic [4:0]       in_writereg,
    output logic             RegWrite,
    output logic [4:0]       writereg,
    output logic [31:0]      writedata,
    output logic             wb_valid,
    output logic [CNT_W-1:0] retired
);

    logic [31:0]      load_data;
    logic             regwrite_d, regwrite_q;
    logic             wb_valid_d, wb_valid_q;
    logic [4:0]       writereg_d, writereg_q;
    logic [31:0]      writedata_d, writedata_q;
    logic [CNT_W-1:0] retired_d, retired_q;

    load_align u_load_align (
        .loadtype (in_loadtype),
        .addr_lo  (in_addr_lo),
        .memdata  (in_memdata),
        .data     (load_data)
    );

    always_comb begin
        regwrite_d  = regwrite_q;
        wb_valid_d  = wb_valid_q;
        writereg_d  = writereg_q;
        writedata_d = writedata_q;
        retired_d   = retired_q;
        if (wb_valid_q && !stall) begin
            retired_d = retired_q + CNT_W'(1);
        end
        if (flush) begin
            regwrite_d  = 1'b0;
            wb_valid_d  = 1'b0;
            writereg_d  = '0;
            writedata_d = '0;
        end else if (stall) begin
            // The held write already happened on the first WB cycle.
            regwrite_d = 1'b0;
        end else begin
            regwrite_d  = in_valid && in_regwrite && (in_writereg != 5'd0);
            wb_valid_d  = in_valid;
            writereg_d  = in_writereg;
            writedata_d = in_memtoreg ? load_data : in_aluresult;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regwrite_q  <= 1'b0;
            wb_valid_q  <= 1'b0;
            writereg_q  <= '0;
            writedata_q <= '0;
            retired_q   <= '0;
        end else begin
            regwrite_q  <= regwrite_d;
            wb_valid_q  <= wb_valid_d;
            writereg_q  <= writereg_d;
            writedata_q <= writedata_d;
            retired_q   <= retired_d;
        end
    end

    assign RegWrite  = regwrite_q;
    assign wb_valid  = wb_valid_q;
    assign writereg  = writereg_q;
    assign writedata = writedata_q;
    assign retired   = retired_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed cases plus randomized traffic vs. a reference model.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_regwrite = 1'b0;
    logic        in_memtoreg = 1'b0;
    logic [2:0]  in_loadtype = 3'd0;
    logic [1:0]  in_addr_lo = 2'd0;
    logic [31:0] in_aluresult = 32'd0;
    logic [31:0] in_memdata = 32'd0;
    logic [4:0]  in_writereg = 5'd0;

    logic        rw_a, vld_a, rw_b, vld_b;
    logic [4:0]  wr_a, wr_b;
    logic [31:0] wd_a, wd_b;
    logic [31:0] ret_a;
    logic [3:0]  ret_b;

    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    logic        m_rw, m_valid;
    logic [4:0]  m_wreg;
    logic [31:0] m_wdata;
    longint      m_ret;

    always #5 clk = ~clk;

    mem_wb_stage #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_regwrite(in_regwrite),
        .in_memtoreg(in_memtoreg), .in_loadtype(in_loadtype),
        .in_addr_lo(in_addr_lo), .in_aluresult(in_aluresult),
        .in_memdata(in_memdata), .in_writereg(in_writereg),
        .RegWrite(rw_a), .writereg(wr_a), .writedata(wd_a),
        .wb_valid(vld_a), .retired(ret_a)
    );

    mem_wb_stage #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_regwrite(in_regwrite),
        .in_memtoreg(in_memtoreg), .in_loadtype(in_loadtype),
        .in_addr_lo(in_addr_lo), .in_aluresult(in_aluresult),
        .in_memdata(in_memdata), .in_writereg(in_writereg),
        .RegWrite(rw_b), .writereg(wr_b), .writedata(wd_b),
        .wb_valid(vld_b), .retired(ret_b)
    );

    function automatic logic [31:0] ref_load(input int lt, input int a, input longint d);
        longint b, h;
        b = (d >> (8 * a)) % 256;
        h = (d >> (16 * (a / 2))) % 65536;
        case (lt)
            1: return (b >= 128) ? 32'(b - 256) : 32'(b);
            2: return 32'(b);
            3: return (h >= 32768) ? 32'(h - 65536) : 32'(h);
            4: return 32'(h);
            default: return 32'(d);
        endcase
    endfunction

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        if (rst) begin
            m_rw = 0; m_valid = 0; m_wreg = 0; m_wdata = 0; m_ret = 0;
        end else begin
            if (m_valid && !stall) m_ret = m_ret + 1;
            if (flush) begin
                m_rw = 0; m_valid = 0; m_wreg = 0; m_wdata = 0;
            end else if (stall) begin
                m_rw = 0;
            end else begin
                m_valid = in_valid;
                m_rw = in_valid && in_regwrite && (in_writereg != 0);
                m_wreg = in_writereg;
                m_wdata = in_memtoreg
                    ? ref_load(int'(in_loadtype), int'(in_addr_lo), longint'(in_memdata))
                    : in_aluresult;
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("RegWrite", rw_a, m_rw);
        chk("wb_valid", vld_a, m_valid);
        chk("writereg", wr_a, m_wreg);
        chk("writedata", wd_a, m_wdata);
        chk("retired", ret_a, m_ret % 64'h1_0000_0000);
        chk("retired4", ret_b, m_ret % 16);
        chk("RegWrite4", rw_b, m_rw);
    endtask

    task automatic drive(input bit v, input bit rw, input bit mtr, input int lt,
                         input int a, input logic [31:0] alu, input logic [31:0] md,
                         input int wr);
        in_valid = v; in_regwrite = rw; in_memtoreg = mtr;
        in_loadtype = 3'(lt); in_addr_lo = 2'(a);
        in_aluresult = alu; in_memdata = md; in_writereg = 5'(wr);
    endtask

    initial begin
        longint r0;
        m_rw = 0; m_valid = 0; m_wreg = 0; m_wdata = 0; m_ret = 0;
        @(negedge clk);
        // reset state
        rst = 1; tick(); rst = 0;
        chk("reset_rw", rw_a, 0);
        chk("reset_ret", ret_a, 0);

        // LB sign-extend of top byte
        drive(1, 1, 1, 1, 3, 32'h0, 32'h80FF7F01, 8); tick();
        chk("lb_data", wd_a, 32'hFFFFFF80);
        chk("lb_rw", rw_a, 1);
        chk("lb_wr", wr_a, 8);

        // LHU / LH upper halfword
        drive(1, 1, 1, 4, 2, 32'h0, 32'h80FF7F01, 9); tick();
        chk("lhu_data", wd_a, 32'h000080FF);
        drive(1, 1, 1, 3, 2, 32'h0, 32'h80FF7F01, 9); tick();
        chk("lh_data", wd_a, 32'hFFFF80FF);

        // $0 suppression
        drive(1, 1, 0, 0, 0, 32'h12345678, 32'h0, 0); tick();
        chk("x0_rw", rw_a, 0);
        chk("x0_valid", vld_a, 1);
        r0 = longint'(ret_a);
        drive(0, 0, 0, 0, 0, 32'h0, 32'h0, 0); tick();
        chk("x0_retire", ret_a, r0 + 1);

        // stall three cycles, then flush+stall
        drive(1, 1, 0, 0, 0, 32'hCAFE0001, 32'h0, 5); tick();
        chk("st_rw0", rw_a, 1);
        r0 = longint'(ret_a);
        drive(1, 1, 0, 0, 0, 32'hDEAD0000, 32'h0, 6);
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("st_rw", rw_a, 0);
            chk("st_wd", wd_a, 32'hCAFE0001);
            chk("st_ret", ret_a, r0);
        end
        flush = 1; tick();
        chk("fl_valid", vld_a, 0);
        chk("fl_wd", wd_a, 0);
        stall = 0; flush = 0;

        // reset during a valid LW
        drive(1, 1, 1, 0, 0, 32'h0, 32'h11223344, 7); tick();
        rst = 1; drive(1, 1, 1, 0, 0, 32'h0, 32'h55667788, 10); tick();
        chk("rst_rw", rw_a, 0);
        chk("rst_wd", wd_a, 0);
        chk("rst_valid", vld_a, 0);
        rst = 0;

        // 4-bit counter wrap after 17 retirements
        for (int i = 0; i < 17; i++) begin
            drive(1, 1, 0, 0, 0, 32'(i), 32'h0, 1 + i); tick();
        end
        drive(0, 0, 0, 0, 0, 32'h0, 32'h0, 0); tick();
        chk("wrap4", ret_b, 1);
        chk("wrap32", ret_a, 17);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 1),
                  $urandom_range(0, 7), $urandom_range(0, 3), $urandom, $urandom,
                  ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 31));
            stall = ($urandom_range(0, 4) == 0);
            flush = ($urandom_range(0, 9) == 0);
            rst   = ($urandom_range(0, 49) == 0);
            tick();
        end
        rst = 0; stall = 0; flush = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
Parameter:
REQ-001 SHALL provide CNT_W, default 32: width of the retired-instruction counter.

Ports (name  direction  width  meaning):
REQ-002 SHALL provide clk  in  1  single clock; all state updates on posedge clk.
REQ-003 SHALL provide rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL provide stall  in  1  hold all stage registers.
REQ-005 SHALL provide flush  in  1  replace the captured instruction with a bubble.
REQ-006 SHALL provide in_valid  in  1  MEM stage holds a real instruction.
REQ-007 SHALL provide in_regwrite  in  1  instruction writes a GPR.
REQ-008 SHALL provide in_memtoreg  in  1  1 = load data, 0 = ALU result.
REQ-009 SHALL provide in_loadtype  in  3  0 LW, 1 LB, 2 LBU, 3 LH, 4 LHU; 5-7 treated as LW.
REQ-010 SHALL provide in_addr_lo  in  2  effective address bits [1:0].
REQ-011 SHALL provide in_aluresult  in  32  ALU result.
REQ-012 SHALL provide in_memdata  in  32  raw data-memory word.
REQ-013 SHALL provide in_writereg  in  5  destination register.
REQ-014 SHALL provide RegWrite  out  1  register-file write enable.
REQ-015 SHALL provide writereg  out  5  register-file write address.
REQ-016 SHALL provide writedata  out  32  register-file write data.
REQ-017 SHALL provide wb_valid  out  1  WB stage holds a real instruction.
REQ-018 SHALL provide retired  out  CNT_W  count of instructions retired through WB.

Function
REQ-019 SHALL register all outputs; latency from MEM inputs to WB outputs is exactly one clock.
REQ-020 SHALL compute load data before the register, little-endian.
- LB/LBU select byte in_addr_lo: 0 -> [7:0], 1 -> [15:8], 2 -> [23:16], 3 -> [31:24].
- LH/LHU select halfword in_addr_lo[1]: 0 -> [15:0], 1 -> [31:16]; in_addr_lo[0] ignored.
- LB/LH sign-extend; LBU/LHU zero-extend.
REQ-021 SHALL capture writedata = in_memtoreg ? extracted load data : in_aluresult.
REQ-022 SHALL capture RegWrite = in_valid & in_regwrite & (in_writereg != 0); writes to $0 never leave the stage.
REQ-023 SHALL capture writereg and writedata unconditionally when advancing; their values are don't-care while RegWrite is 0.
REQ-024 SHALL, on a cycle with stall=1 and flush=0, hold every output register and the counter unchanged.
REQ-025 SHALL, on a cycle with flush=1, load a bubble: RegWrite=0, wb_valid=0, writereg=0, writedata=0; flush overrides stall.
REQ-026 SHALL increment retired by 1 on each posedge where wb_valid=1 and stall=0, counting the instruction that leaves WB; flush does not suppress an increment for the instruction already in WB.
REQ-027 SHALL let retired wrap from all-ones to 0 without any flag.
REQ-028 SHALL NOT let stall hold RegWrite active for repeated writes; when stall=1, RegWrite SHALL be forced to 0 at the output (the held write already occurred on its first cycle).

Reset
REQ-029 SHALL, when rst=1 at posedge clk, set RegWrite=0, wb_valid=0, writereg=0, writedata=0, retired=0, regardless of stall and flush.
REQ-030 SHALL, when rst is asserted mid-operation, discard the instruction in flight with no register-file write.

Structure
REQ-031 SHALL place the load-type encodings (LW, LB, LBU, LH, LHU) in the shared pipeline package used by the ID and MEM stages.
REQ-032 SHALL implement load extraction as the combinational sub-module load_align (inputs: loadtype, addr_lo, memdata; output: 32-bit data).

Verification
REQ-033 SHALL verify LB: memdata=0x80FF7F01, addr_lo=3, memtoreg=1, regwrite=1, writereg=8 -> next cycle writedata=0xFFFFFF80, RegWrite=1, writereg=8.
REQ-034 SHALL verify LHU: memdata=0x80FF7F01, addr_lo=2 -> writedata=0x000080FF; LH with the same inputs -> writedata=0xFFFF80FF.
REQ-035 SHALL verify $0 suppression: ALU result 0x12345678, writereg=0, regwrite=1 -> RegWrite=0, wb_valid=1, retired increments once.
REQ-036 SHALL verify stall and flush together: stall=1 for 3 cycles -> outputs held, RegWrite=0 after the first cycle, retired unchanged; then flush=1 with stall=1 -> bubble, wb_valid=0.
REQ-037 SHALL verify counter wrap: CNT_W=4 with 17 valid instructions -> retired=1.
REQ-038 SHALL verify reset: rst=1 during a valid LW -> all outputs 0 next cycle, no write.
